// File: rtl/pong_ball_ctrl.sv
// Ball-motion scheduler and game-state sequencer for the pong display path.
// Holds the ball at the serve point, advances it once per video frame, and
// resolves wall, computer-paddle and player-paddle bounces.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   start          start/restart request (level, sampled every clk)
//   frame_tick     one-clk pulse per video frame
//   x_paddle_left  player paddle left x
//   x_paddle_right player paddle right x
//   ball_x         ball centre x (registered)
//   ball_y         ball centre y (registered)
//   lose           player missed, held until restart (registered)
//   hits           player paddle hits this game, saturating (registered)
//   playing        high while in PLAY (registered)
module pong_ball_ctrl #(
  parameter int unsigned SPEED_X      = 2,
  parameter int unsigned SPEED_Y      = 2,
  parameter int unsigned RADIUS       = 10,
  parameter int unsigned START_X      = 320,
  parameter int unsigned START_Y      = 240,
  parameter int unsigned COMP_BOTTOM  = 10,
  parameter int unsigned PADDLE_TOP   = 470,
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic [9:0] x_paddle_left,
  input  logic [9:0] x_paddle_right,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       lose,
  output logic [7:0] hits,
  output logic       playing
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned HW = 8;
  localparam int unsigned CW = $clog2(SERVE_FRAMES + 1);

  // Motion limits, all in the 11-bit signed domain of the next-position math.
  localparam logic signed [10:0] SX    = 11'(SPEED_X);
  localparam logic signed [10:0] SY    = 11'(SPEED_Y);
  localparam logic signed [10:0] X_MIN = 11'(RADIUS);
  localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1 - RADIUS);
  localparam logic signed [10:0] Y_TOP = 11'(COMP_BOTTOM + RADIUS);
  localparam logic signed [10:0] Y_BOT = 11'(PADDLE_TOP - RADIUS);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, LOSE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   ball_x_d;
  logic [YW-1:0]   ball_y_d;
  logic            dx_q, dx_d;          // 1 = moving right
  logic            dy_q, dy_d;          // 1 = moving down
  logic            serve_dir_q, serve_dir_d;
  logic [HW-1:0]   hits_d;
  logic            lose_d;
  logic            playing_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic signed [10:0] bx_s, by_s, nx, ny;
  logic               on_paddle;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ball_x      <= XW'(START_X);
      ball_y      <= YW'(START_Y);
      dx_q        <= 1'b1;
      dy_q        <= 1'b0;
      serve_dir_q <= 1'b1;
      hits        <= '0;
      lose        <= 1'b0;
      playing     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ball_x      <= ball_x_d;
      ball_y      <= ball_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      serve_dir_q <= serve_dir_d;
      hits        <= hits_d;
      lose        <= lose_d;
      playing     <= playing_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x;
    ball_y_d    = ball_y;
    dx_d        = dx_q;
    dy_d        = dy_q;
    serve_dir_d = serve_dir_q;
    hits_d      = hits;
    lose_d      = lose;
    cnt_d       = cnt_q;

    bx_s      = $signed({1'b0, ball_x});
    by_s      = $signed({2'b00, ball_y});
    nx        = dx_q ? (bx_s + SX) : (bx_s - SX);
    ny        = dy_q ? (by_s + SY) : (by_s - SY);
    on_paddle = (x_paddle_left <= ball_x) && (ball_x <= x_paddle_right);

    case (state_q)
      IDLE, LOSE: begin
        // start has priority over any tick in these states.
        if (start) begin
          state_d     = SERVE;
          ball_x_d    = XW'(START_X);
          ball_y_d    = YW'(START_Y);
          dx_d        = serve_dir_q;
          dy_d        = 1'b0;
          serve_dir_d = ~serve_dir_q;
          hits_d      = '0;
          lose_d      = 1'b0;
          cnt_d       = CW'(SERVE_FRAMES);
        end
      end

      SERVE: begin
        if (frame_tick) begin
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      PLAY: begin
        if (frame_tick) begin
          if ((ny >= Y_BOT) && !on_paddle) begin
            // Miss: freeze everything at the pre-tick position.
            state_d = LOSE;
            lose_d  = 1'b1;
          end else begin
            // Axes resolve independently so a corner reverses both.
            if (nx <= X_MIN) begin
              ball_x_d = XW'(X_MIN);
              dx_d     = 1'b1;
            end else if (nx >= X_MAX) begin
              ball_x_d = XW'(X_MAX);
              dx_d     = 1'b0;
            end else begin
              ball_x_d = XW'(nx);
            end

            if (ny <= Y_TOP) begin
              ball_y_d = YW'(COMP_BOTTOM + 1 + RADIUS);
              dy_d     = 1'b1;
            end else if (ny >= Y_BOT) begin
              ball_y_d = YW'(Y_BOT);
              dy_d     = 1'b0;
              if (hits != {HW{1'b1}}) hits_d = hits + HW'(1);
            end else begin
              ball_y_d = YW'(ny);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    playing_d = (state_d == PLAY);
  end

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed self-checking bench for pong_ball_ctrl. A second instance with a
// shifted serve x is used to reach a simultaneous right-wall/top bounce.
module tb_pong_ball_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start2;
  logic       frame_tick;
  logic [9:0] x_paddle_left, x_paddle_right;

  logic [9:0] ball_x, b_ball_x;
  logic [8:0] ball_y, b_ball_y;
  logic       lose, b_lose;
  logic [7:0] hits, b_hits;
  logic       playing, b_playing;

  logic [28:0] obs, obs2, exp;
  int n_checks = 0;
  int n_fail   = 0;

  assign obs  = {ball_x, ball_y, lose, hits, playing};
  assign obs2 = {b_ball_x, b_ball_y, b_lose, b_hits, b_playing};

  always #5 clk = ~clk;

  pong_ball_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .x_paddle_left(x_paddle_left), .x_paddle_right(x_paddle_right),
    .ball_x(ball_x), .ball_y(ball_y), .lose(lose), .hits(hits),
    .playing(playing)
  );

  pong_ball_ctrl #(.START_X(410)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .frame_tick(frame_tick),
    .x_paddle_left(x_paddle_left), .x_paddle_right(x_paddle_right),
    .ball_x(b_ball_x), .ball_y(b_ball_y), .lose(b_lose), .hits(b_hits),
    .playing(b_playing)
  );

  function automatic string fmt(input logic [28:0] v);
    return $sformatf("x=%0d y=%0d lose=%0b hits=%0d playing=%0b",
                     v[28:19], v[18:10], v[9], v[8:1], v[0]);
  endfunction

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; start2 = 1'b0; frame_tick = 1'b0;
    x_paddle_left = 10'd0; x_paddle_right = 10'd0;
    #12;
    exp = {10'd320, 9'd240, 1'b0, 8'd0, 1'b0}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset_vals: got %s want %s", fmt(obs), fmt(exp)); end
    exp = {10'd410, 9'd240, 1'b0, 8'd0, 1'b0}; n_checks++;
    if (obs2 !== exp) begin n_fail++; $display("FAIL reset_vals2: got %s want %s", fmt(obs2), fmt(exp)); end
    @(negedge clk) reset = 1'b1;
    tick_n(2);
    exp = {10'd320, 9'd240, 1'b0, 8'd0, 1'b0}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL idle_ignores_tick: got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_serve;
    pulse_start;
    exp = {10'd320, 9'd240, 1'b0, 8'd0, 1'b0}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL serve_entry: got %s want %s", fmt(obs), fmt(exp)); end
    tick_n(59);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL serve_tick59: got %s want %s", fmt(obs), fmt(exp)); end
    tick_n(1);
    exp = {10'd320, 9'd240, 1'b0, 8'd0, 1'b1}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL serve_tick60: got %s want %s", fmt(obs), fmt(exp)); end
    tick_n(1);
    exp = {10'd322, 9'd238, 1'b0, 8'd0, 1'b1}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL first_step: got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_top_bounce;
    tick_n(108);
    exp = {10'd538, 9'd22, 1'b0, 8'd0, 1'b1}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL pre_top: got %s want %s", fmt(obs), fmt(exp)); end
    tick_n(1);
    exp = {10'd540, 9'd21, 1'b0, 8'd0, 1'b1}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL top_clamp: got %s want %s", fmt(obs), fmt(exp)); end
    tick_n(1);
    exp = {10'd542, 9'd23, 1'b0, 8'd0, 1'b1}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL top_reverse: got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_paddle_hit;
    // Right paddle edge equals ball_x: inclusive boundary.
    x_paddle_left = 10'd197; x_paddle_right = 10'd281;
    tick_n(218);
    exp = {10'd281, 9'd459, 1'b0, 8'd0, 1'b1}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL pre_hit: got %s want %s", fmt(obs), fmt(exp)); end
    tick_n(1);
    exp = {10'd279, 9'd460, 1'b0, 8'd1, 1'b1}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL paddle_hit: got %s want %s", fmt(obs), fmt(exp)); end
    tick_n(1);
    exp = {10'd277, 9'd458, 1'b0, 8'd1, 1'b1}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL hit_reverse: got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_miss;
    // Left paddle edge one past ball_x: just a miss.
    x_paddle_left = 10'd619; x_paddle_right = 10'd700;
    tick_n(438);
    exp = {10'd618, 9'd459, 1'b0, 8'd1, 1'b1}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL pre_miss: got %s want %s", fmt(obs), fmt(exp)); end
    tick_n(1);
    exp = {10'd618, 9'd459, 1'b1, 8'd1, 1'b0}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL miss_lose: got %s want %s", fmt(obs), fmt(exp)); end
    tick_n(3);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL lose_frozen: got %s want %s", fmt(obs), fmt(exp)); end
    // start and tick together in LOSE: start wins, tick not counted.
    @(negedge clk) begin start = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin start = 1'b0; frame_tick = 1'b0; end
    exp = {10'd320, 9'd240, 1'b0, 8'd0, 1'b0}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL restart: got %s want %s", fmt(obs), fmt(exp)); end
    tick_n(30);
    pulse_start;
    tick_n(29);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL serve2_tick59: got %s want %s", fmt(obs), fmt(exp)); end
    tick_n(1);
    exp = {10'd320, 9'd240, 1'b0, 8'd0, 1'b1}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL serve2_tick60: got %s want %s", fmt(obs), fmt(exp)); end
    tick_n(1);
    exp = {10'd318, 9'd238, 1'b0, 8'd0, 1'b1}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL serve_dir_toggle: got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_corner;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    tick_n(60);
    exp = {10'd410, 9'd240, 1'b0, 8'd0, 1'b1}; n_checks++;
    if (obs2 !== exp) begin n_fail++; $display("FAIL corner_serve: got %s want %s", fmt(obs2), fmt(exp)); end
    tick_n(109);
    exp = {10'd628, 9'd22, 1'b0, 8'd0, 1'b1}; n_checks++;
    if (obs2 !== exp) begin n_fail++; $display("FAIL pre_corner: got %s want %s", fmt(obs2), fmt(exp)); end
    tick_n(1);
    exp = {10'd629, 9'd21, 1'b0, 8'd0, 1'b1}; n_checks++;
    if (obs2 !== exp) begin n_fail++; $display("FAIL corner_clamp: got %s want %s", fmt(obs2), fmt(exp)); end
    tick_n(1);
    exp = {10'd627, 9'd23, 1'b0, 8'd0, 1'b1}; n_checks++;
    if (obs2 !== exp) begin n_fail++; $display("FAIL corner_reverse: got %s want %s", fmt(obs2), fmt(exp)); end
  endtask

  task automatic test_async_reset;
    n_checks++;
    if (playing !== 1'b1) begin n_fail++; $display("FAIL pre_reset_play: got %0b want 1", playing); end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    exp = {10'd320, 9'd240, 1'b0, 8'd0, 1'b0}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL async_reset: got %s want %s", fmt(obs), fmt(exp)); end
    exp = {10'd410, 9'd240, 1'b0, 8'd0, 1'b0}; n_checks++;
    if (obs2 !== exp) begin n_fail++; $display("FAIL async_reset2: got %s want %s", fmt(obs2), fmt(exp)); end
    tick_n(2);
    @(negedge clk) reset = 1'b1;
    tick_n(2);
    exp = {10'd320, 9'd240, 1'b0, 8'd0, 1'b0}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL post_reset_idle: got %s want %s", fmt(obs), fmt(exp)); end
    pulse_start;
    tick_n(61);
    exp = {10'd322, 9'd238, 1'b0, 8'd0, 1'b1}; n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL post_reset_serve_dir: got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  initial begin
    test_reset;
    test_serve;
    test_top_bounce;
    test_paddle_hit;
    test_miss;
    test_corner;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
